// File: rtl/conv_window_streamer.sv
// Sliding column-window feeder: fetches image columns from word-wide memory, adds zero
// padding, and hands out each stride-aligned KERNEL_SIZE-column window over valid/ready.
module conv_window_streamer #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned WORD_LANES  = 16,
    parameter int unsigned IMAGE_SIZE  = 28,
    parameter int unsigned KERNEL_SIZE = 5,
    parameter int unsigned STRIDE      = 1,
    parameter int unsigned PADDING     = 1,
    parameter int unsigned ADDR_WIDTH  = 12
) (
    input  logic                                                          clk,
    input  logic                                                          rst,
    input  logic                                                          start,
    input  logic                                                          abort,
    input  logic [ADDR_WIDTH-1:0]                                         image_base,
    output logic                                                          rd_en,
    output logic [ADDR_WIDTH-1:0]                                         rd_addr,
    input  logic [DATA_WIDTH*WORD_LANES-1:0]                              rd_data,
    output logic                                                          win_valid,
    input  logic                                                          win_ready,
    output logic [KERNEL_SIZE*(IMAGE_SIZE+2*PADDING)*DATA_WIDTH-1:0]      win_data,
    output logic [$clog2((IMAGE_SIZE+2*PADDING-KERNEL_SIZE)/STRIDE+2)-1:0] win_col,
    output logic                                                          win_last,
    output logic                                                          busy,
    output logic                                                          done
);

    localparam int unsigned P       = IMAGE_SIZE + 2 * PADDING;
    localparam int unsigned WPC     = (IMAGE_SIZE + WORD_LANES - 1) / WORD_LANES;
    localparam int unsigned OUT     = (P - KERNEL_SIZE) / STRIDE + 1;
    localparam int unsigned PcW     = $clog2(P + 1);
    localparam int unsigned WordW   = (WPC > 1) ? $clog2(WPC) : 1;
    localparam int unsigned NeedW   = $clog2(KERNEL_SIZE + 1);
    localparam int unsigned ColW    = $clog2(OUT + 1);
    localparam int unsigned ColBits = P * DATA_WIDTH;

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StShift, StEmit} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [PcW-1:0]          pc_q, pc_d;
    logic [WordW-1:0]        word_q, word_d;
    logic [NeedW-1:0]        need_q, need_d;
    logic [ColW-1:0]         col_idx_q, col_idx_d;
    logic                    done_q, done_d;
    logic                    shift_en;
    logic                    cap_valid_q;
    logic [WordW-1:0]        cap_word_q;
    logic [ColBits-1:0]      column_q;
    logic [ColBits-1:0]      win_q [KERNEL_SIZE];
    logic [ADDR_WIDTH-1:0]   img_col;
    logic                    last_win;
    logic                    unused_rd;

    function automatic logic is_pad(input logic [PcW-1:0] pc);
        return (int'(pc) < int'(PADDING)) || (int'(pc) >= int'(PADDING + IMAGE_SIZE));
    endfunction

    // Lanes past the last image row are never looked at.
    assign unused_rd = ^rd_data;

    assign img_col   = ADDR_WIDTH'(pc_q) - ADDR_WIDTH'(PADDING);
    assign rd_en     = (state_q == StFetch);
    assign rd_addr   = rd_en ? (base_q + img_col * ADDR_WIDTH'(WPC) + ADDR_WIDTH'(word_q)) : '0;
    assign win_valid = (state_q == StEmit);
    assign last_win  = win_valid && (col_idx_q == ColW'(OUT - 1));
    assign win_last  = last_win;
    assign win_col   = col_idx_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

    for (genvar kc = 0; kc < KERNEL_SIZE; kc++) begin : g_win_out
        assign win_data[kc*ColBits +: ColBits] = win_q[kc];
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        pc_d      = pc_q;
        word_d    = word_q;
        need_d    = need_q;
        col_idx_d = col_idx_q;
        done_d    = 1'b0;
        shift_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d    = image_base;
                    pc_d      = '0;
                    word_d    = '0;
                    need_d    = NeedW'(KERNEL_SIZE);
                    col_idx_d = '0;
                    state_d   = is_pad(PcW'(0)) ? StShift : StFetch;
                end
            end
            StFetch: begin
                if (word_q == WordW'(WPC - 1)) begin
                    word_d  = '0;
                    state_d = StWait;
                end else begin
                    word_d = word_q + 1'b1;
                end
            end
            StWait: state_d = StShift;
            StShift: begin
                shift_en = 1'b1;
                pc_d     = pc_q + 1'b1;
                need_d   = need_q - 1'b1;
                if (need_q == NeedW'(1)) begin
                    state_d = StEmit;
                end else begin
                    state_d = is_pad(pc_q + 1'b1) ? StShift : StFetch;
                end
            end
            StEmit: begin
                if (win_ready) begin
                    if (last_win) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        col_idx_d = col_idx_q + 1'b1;
                        need_d    = NeedW'(STRIDE);
                        state_d   = is_pad(pc_q) ? StShift : StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort wins over a simultaneous handshake and suppresses done.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            pc_q        <= '0;
            word_q      <= '0;
            need_q      <= '0;
            col_idx_q   <= '0;
            done_q      <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_word_q  <= '0;
            column_q    <= '0;
            for (int kc = 0; kc < KERNEL_SIZE; kc++) begin
                win_q[kc] <= '0;
            end
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            pc_q        <= pc_d;
            word_q      <= word_d;
            need_q      <= need_d;
            col_idx_q   <= col_idx_d;
            done_q      <= done_d;
            cap_valid_q <= rd_en;
            cap_word_q  <= word_q;
            // Memory answers one cycle after the strobe; pad rows of column_q stay zero.
            if (cap_valid_q) begin
                for (int r = 0; r < IMAGE_SIZE; r++) begin
                    if (cap_word_q == WordW'(r / WORD_LANES)) begin
                        column_q[(PADDING + r)*DATA_WIDTH +: DATA_WIDTH] <=
                            rd_data[(r % WORD_LANES)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            if (shift_en) begin
                for (int kc = 0; kc < KERNEL_SIZE - 1; kc++) begin
                    win_q[kc] <= win_q[kc+1];
                end
                win_q[KERNEL_SIZE-1] <= is_pad(pc_q) ? '0 : column_q;
            end
        end
    end

endmodule

// File: doc/conv_window_streamer.md
# conv_window_streamer

Parametrised column-window feeder for the FP16 convolution datapath. It fetches image columns from a word-wide image memory, inserts zero padding, and maintains a sliding KERNEL_SIZE-column window. It emits each stride-aligned window over a valid/ready handshake to the downstream PE array. It supersedes the fixed-size 28x28 / 5x5 / unit-stride column front end with runtime base address, real padding, stride, abort and backpressure.

## Interface
Parameters:
- DATA_WIDTH, 16, element width (FP16, passed through untouched)
- WORD_LANES, 16, elements per memory word
- IMAGE_SIZE, 28, square image side
- KERNEL_SIZE, 5, window width in columns; legal range 1..P
- STRIDE, 1, column stride; legal range 1..KERNEL_SIZE
- PADDING, 1, zero border on each side
- ADDR_WIDTH, 12, memory address width
- Derived: P = IMAGE_SIZE+2*PADDING; WPC = ceil(IMAGE_SIZE/WORD_LANES); OUT = (P-KERNEL_SIZE)/STRIDE+1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  synchronous cancel; return to IDLE next cycle, no done
- image_base  in  ADDR_WIDTH  frame base address; captured on start
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_WIDTH  image_base + c*WPC + w (c = image column, w = word)
- rd_data  in  DATA_WIDTH*WORD_LANES  read data, valid the cycle after rd_en
- win_valid  out  1  window available
- win_ready  in  1  downstream accepts
- win_data  out  KERNEL_SIZE*P*DATA_WIDTH  element (kc,r) at bit offset (kc*P+r)*DATA_WIDTH; kc=0 is the oldest column
- win_col  out  $clog2(OUT+1)  output column index of current window
- win_last  out  1  current window is index OUT-1
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, FETCH, WAIT, SHIFT, EMIT.
- IDLE + start: capture image_base; clear pc (padded column), need = KERNEL_SIZE, win_col = 0. Go to SHIFT if pc is a pad column, otherwise go to FETCH.
- Pad column (pc < PADDING or pc >= PADDING+IMAGE_SIZE): no reads; the column is all zeros.
- FETCH: issue WPC reads, one per cycle, for image column c = pc-PADDING, with w = 0..WPC-1. Lane j of word w is image row w*WORD_LANES+j and lands at padded row +PADDING. Lanes at or beyond IMAGE_SIZE are discarded. Padded rows outside the image are zero.
- WAIT: one cycle to capture the last word. Then go to SHIFT.
- SHIFT: window slot kc ← slot kc+1; slot KERNEL_SIZE-1 ← assembled column. Then pc++ and need--.
  - If need reaches 0, go to EMIT.
  - Otherwise fetch the next column (FETCH, or SHIFT for a pad column).
- EMIT: win_valid=1.
  - Hold win_data, win_col and win_last stable until win_valid && win_ready.
  - On handshake, if win_last: return to IDLE and pulse done.
  - On handshake otherwise: win_col++, need = STRIDE, and fetch the next column.
- Padded columns beyond the last used one ((P-KERNEL_SIZE) mod STRIDE columns) are never fetched.
- No reads are issued during EMIT or IDLE.
- abort, in any non-IDLE state: next state IDLE. win_valid drops next cycle, no done pulse, window contents don't care. abort has priority over handshake.
- start while busy is ignored.

## Timing
- Reset values: rd_en=0, rd_addr=0, win_valid=0, win_data=0, win_col=0, win_last=0, busy=0, done=0, state IDLE. Async assert; reset mid-frame discards everything.
- Cycle 1 = first cycle after the start-sampling edge. busy is high from cycle 1 through the final handshake cycle, and low on the done cycle.
- Real column: WPC read cycles + 1 WAIT + 1 SHIFT = WPC+2 cycles. Pad column: 1 cycle.
- Memory latency is fixed at 1. rd_data is captured on the edge ending the cycle after rd_en.
- Defaults (P=30, WPC=2, OUT=26): first win_valid in cycle 18, at 1 + 4×4 cycles of fill.
- With win_ready held high, one window per 5 cycles during steady state, and one per 2 cycles while in the trailing pad columns.
- done pulses the cycle after the win_last handshake.

## Test plan
- Defaults, memory word = address pattern, win_ready=1, image_base=0x100:
  - 26 windows; win_col 0..25; win_last only on 25; done once.
  - First window kc=0 all zero.
  - kc=1 row 1 = data at 0x100 lane 0; rows 0 and 29 zero.
  - Reads 0x100..0x137 each exactly once, in order.
- STRIDE=2, PADDING=0, KERNEL_SIZE=5: OUT=12; window n covers image columns 2n..2n+4; image column 27 is never read.
- Backpressure: win_ready low 10 cycles on window 3 → win_valid, win_data and win_col stable, rd_en=0 throughout; window 4 data is correct afterwards.
- abort asserted during FETCH of column 7 → IDLE next cycle, no done. A subsequent start gives a clean frame identical to the reference run.
- rst low during EMIT of window 5 → all outputs at reset values immediately. After release, start → full correct frame.
- IMAGE_SIZE=20, WORD_LANES=16: WPC=2; lanes 4..15 of odd words ignored; padded row 21 is zero.
